// File: rtl/hc_pkg.sv
// Shared constants for the universal shift/latch block: mode encodings
// and the width of the frame counter.
package hc_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Frame counter width; FRAME_LEN up to 255 keeps the last count in range.
    localparam int CNT_W = 8;

    // True for the two modes that move data through the shift stage.
    function automatic logic is_shift(input mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Counts shift edges within a frame and raises a registered single-cycle
// done pulse on the edge that completes FRAME_LEN shifts.
module frame_counter
    import hc_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    // Next count: clear wins, a shift advances and wraps after LAST, otherwise hold.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            if (count_q == LAST) begin
                count_d = '0;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Counter and done pulse registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = done_q;

endmodule

// File: rtl/univ_shift_latch.sv
// Universal shift register with a separate output latch stage, tri-state
// parallel output, complemented output, cascade bit and frame-done pulse.
module univ_shift_latch
    import hc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_i,
    input  logic             ser_r_i,
    input  logic             ser_l_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             clr_i,
    input  logic             latch_i,
    input  logic             oe_n_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qn_o,
    output logic             sh_out_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] frame_count_o
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("univ_shift_latch: WIDTH must be in 2..32");
    end
    if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_bad_frame_len
        $error("univ_shift_latch: FRAME_LEN must be in 1..255");
    end

    mode_e            mode;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] oreg_q;
    logic             cnt_inc;
    logic             cnt_clr;

    assign mode = mode_e'(mode_i);

    // Shift stage next state: clear overrides every mode.
    always_comb begin
        sreg_d = sreg_q;
        if (clr_i) begin
            sreg_d = '0;
        end else begin
            case (mode)
                MODE_SHR:  sreg_d = {ser_r_i, sreg_q[WIDTH-1:1]};
                MODE_SHL:  sreg_d = {sreg_q[WIDTH-2:0], ser_l_i};
                MODE_LOAD: sreg_d = d_i;
                default:   sreg_d = sreg_q;
            endcase
        end
    end

    // Shift stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    // Output stage captures the pre-edge shift stage, independent of clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_q <= '0;
        end else if (latch_i) begin
            oreg_q <= sreg_q;
        end
    end

    // A frame restarts on load or clear; only real shifts advance it.
    assign cnt_inc = !clr_i && is_shift(mode);
    assign cnt_clr = clr_i || (mode == MODE_LOAD);

    frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (cnt_inc),
        .clr_i   (cnt_clr),
        .count_o (frame_count_o),
        .done_o  (frame_done_o)
    );

    // Outputs are decoded straight from the registers.
    assign q_o      = oe_n_i ? {WIDTH{1'bz}} : oreg_q;
    assign qn_o     = ~oreg_q;
    assign sh_out_o = (mode == MODE_SHR) ? sreg_q[0] : sreg_q[WIDTH-1];

endmodule

// File: doc/univ_shift_latch.md
UNIV_SHIFT_LATCH -- requirements
Module: univ_shift_latch

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits, legal range 2..32.
REQ-002 Parameter FRAME_LEN, default 8, shift count per frame, legal range 1..255.
REQ-003 Clk  input  1  single clock; all state SHALL change on rising edge only, except reset.
REQ-004 Reset  input  1  asynchronous, active-low reset; low SHALL clear all state immediately.
REQ-005 Mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 Ser_r  input  1  serial data entering bit WIDTH-1 on shift right.
REQ-007 Ser_l  input  1  serial data entering bit 0 on shift left.
REQ-008 D  input  WIDTH  parallel load data.
REQ-009 Clr  input  1  synchronous clear of the shift stage and frame counter, active-high.
REQ-010 Latch  input  1  copies the shift stage into the output stage, active-high.
REQ-011 Oe_n  input  1  output enable, active-low; high SHALL drive Q to high impedance.
REQ-012 Q  output  WIDTH  output stage, tri-stated by Oe_n.
REQ-013 Qn  output  WIDTH  bitwise complement of the output stage; never tri-stated.
REQ-014 Sh_out  output  1  cascade output: bit 0 in shift-right mode, bit WIDTH-1 otherwise.
REQ-015 Frame_done  output  1  single-cycle pulse on completion of FRAME_LEN shifts.

Function
REQ-016 Two stages SHALL exist: a shift stage (sreg) and an output stage (oreg), each WIDTH bits.
REQ-017 Shift right: sreg becomes {Ser_r, sreg[WIDTH-1:1]}; shift left: sreg becomes {sreg[WIDTH-2:0], Ser_l}.
REQ-018 Parallel load: sreg becomes D on the edge; hold: sreg unchanged.
REQ-019 Priority SHALL be Clr > Mode; while Clr is high, sreg clears to 0 and the counter clears to 0 regardless of Mode.
REQ-020 When Latch is high, oreg SHALL capture the pre-edge sreg value, so Latch and a shift on the same edge latch the old contents.
REQ-021 Latch SHALL be independent of Clr; with both high on one edge, oreg gets the old sreg and sreg becomes 0.
REQ-022 Frame counter (8-bit) SHALL increment on each shift edge (Mode 01 or 10 with Clr low).
REQ-023 Counter SHALL clear on parallel load and on Clr.
REQ-024 At count FRAME_LEN-1 plus a shift, the counter SHALL wrap to 0 and Frame_done SHALL be high for exactly the next cycle.
REQ-025 Hold cycles inside a frame SHALL neither advance nor clear the counter.
REQ-026 Q, Qn and Sh_out SHALL be combinational from the registers; Frame_done SHALL be registered.
REQ-027 Latency: a shift or load SHALL be visible on Sh_out 1 cycle after the edge and on Q 1 cycle after the next Latch edge.

Reset
REQ-028 Reset low SHALL force sreg=0, oreg=0, counter=0, Frame_done=0 asynchronously.
REQ-029 Reset low SHALL make Q=0 (if Oe_n low), Qn=all ones, and Sh_out=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no Frame_done pulse.
REQ-031 After Reset rises, the first active edge SHALL operate normally with no extra latency.

Structure
REQ-032 Package hc_pkg SHALL hold the Mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and the counter width constant.
REQ-033 The frame counter SHALL be a sub-module, frame_counter, with inputs inc and clr and outputs count and done.
REQ-034 Parameter legality SHALL be checked at elaboration.

Verification (WIDTH=8, FRAME_LEN=8)
REQ-035 Reset low mid-operation -> Q=00, Qn=FF, Frame_done=0 immediately, with no clock needed.
REQ-036 Load D=A5, Latch, Oe_n=0 -> Q=A5, Qn=5A; then Oe_n=1 -> Q=ZZ while Qn stays 5A.
REQ-037 8 shift-right edges with Ser_r=1,0,1,1,0,0,1,0, then Latch -> Q=4D; Frame_done high for the one cycle after the 8th shift only.
REQ-038 Load 81, then shift left with Latch on the same edge, Ser_l=0 -> Q=81 (old contents), then Latch again -> Q=02, Sh_out=0.
REQ-039 Clr and Mode=11 with D=FF on one edge -> sreg=00 and counter=0; 3 shifts, 1 hold, 5 shifts -> Frame_done after the 8th shift, then the count continues at 1.
REQ-040 4 shifts, then Reset pulse, then 8 shifts -> no pulse from the aborted frame and exactly one pulse after the 8th post-reset shift.
